// File: rtl/demux1to4_8_wb.sv
// Write-back demultiplexer: steers one bus result into one of four destination
// registers, with a valid/ready handshake and a one-entry skid buffer for stalls.
module demux1to4_8_wb #(
   parameter int unsigned      WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_sel,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             hold,
   output logic [WIDTH-1:0] out0,
   output logic [WIDTH-1:0] out1,
   output logic [WIDTH-1:0] out2,
   output logic [WIDTH-1:0] out3,
   output logic [3:0]       wr_pulse,
   output logic             pending
);

   typedef enum logic {
      IDLE = 1'b0,
      PEND = 1'b1
   } state_t;

   state_t           state;
   logic [WIDTH-1:0] dest [4];
   logic [WIDTH-1:0] skid_data;
   logic [1:0]       skid_sel;
   logic             accept;

   function automatic logic [3:0] onehot(input logic [1:0] sel);
      onehot = 4'b0001 << sel;
   endfunction

   assign pending  = (state == PEND);
   assign in_ready = ~pending;
   assign accept   = in_valid & in_ready;

   // A stalled accept is parked and only committed once hold drops; while
   // parked the input is refused, so at most one commit happens per cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         dest[0]   <= RESET_VAL;
         dest[1]   <= RESET_VAL;
         dest[2]   <= RESET_VAL;
         dest[3]   <= RESET_VAL;
         skid_data <= '0;
         skid_sel  <= 2'd0;
         wr_pulse  <= 4'b0000;
      end else begin
         wr_pulse <= 4'b0000;
         case (state)
            IDLE: begin
               if (accept) begin
                  if (hold) begin
                     skid_data <= in_data;
                     skid_sel  <= in_sel;
                     state     <= PEND;
                  end else begin
                     dest[in_sel] <= in_data;
                     wr_pulse     <= onehot(in_sel);
                  end
               end
            end
            PEND: begin
               if (!hold) begin
                  dest[skid_sel] <= skid_data;
                  wr_pulse       <= onehot(skid_sel);
                  state          <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign out0 = dest[0];
   assign out1 = dest[1];
   assign out2 = dest[2];
   assign out3 = dest[3];

endmodule

// File: tb/tb_demux1to4_8_wb.sv
// Bench for demux1to4_8_wb: directed scenarios plus random traffic, checked
// against a transaction-level model of the destination registers.
module tb_demux1to4_8_wb;

   logic       clk;
   logic       rst_n;
   logic [7:0] in_data;
   logic [1:0] in_sel;
   logic       in_valid;
   logic       in_ready;
   logic       hold;
   logic [7:0] out0, out1, out2, out3;
   logic [3:0] wr_pulse;
   logic       pending;

   int tests_run;
   int tests_failed;

   // Reference state: register contents, last-cycle pulse, parked transaction.
   logic [7:0] m_out [4];
   logic [3:0] m_pulse;
   logic       m_parked;
   logic [7:0] m_park_data;
   logic [1:0] m_park_sel;

   demux1to4_8_wb #(.WIDTH(8), .RESET_VAL(8'h00)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data),
      .in_sel   (in_sel),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .hold     (hold),
      .out0     (out0),
      .out1     (out1),
      .out2     (out2),
      .out3     (out3),
      .wr_pulse (wr_pulse),
      .pending  (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests_run++;
      if (observed !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic modelReset();
      for (int i = 0; i < 4; i++) m_out[i] = 8'h00;
      m_pulse     = 4'b0000;
      m_parked    = 1'b0;
      m_park_data = 8'h00;
      m_park_sel  = 2'd0;
   endtask

   task automatic checkAll(input string tag);
      checkOutput({tag, ".out0"}, {24'd0, out0}, {24'd0, m_out[0]});
      checkOutput({tag, ".out1"}, {24'd0, out1}, {24'd0, m_out[1]});
      checkOutput({tag, ".out2"}, {24'd0, out2}, {24'd0, m_out[2]});
      checkOutput({tag, ".out3"}, {24'd0, out3}, {24'd0, m_out[3]});
      checkOutput({tag, ".wr_pulse"}, {28'd0, wr_pulse}, {28'd0, m_pulse});
      checkOutput({tag, ".pending"}, {31'd0, pending}, {31'd0, m_parked});
      checkOutput({tag, ".in_ready"}, {31'd0, in_ready}, {31'd0, ~m_parked});
   endtask

   // Drive one cycle at the falling edge, advance the model per the
   // transaction rules, then compare just after the rising edge.
   task automatic applyStimulus(input logic v, input logic [7:0] d, input logic [1:0] s,
                                input logic h, input string tag);
      logic acc;
      @(negedge clk);
      in_valid = v;
      in_data  = d;
      in_sel   = s;
      hold     = h;
      #1;
      checkOutput({tag, ".ready_pre"}, {31'd0, in_ready}, {31'd0, ~m_parked});
      acc     = v && !m_parked;
      m_pulse = 4'b0000;
      if (m_parked) begin
         if (!h) begin
            m_out[m_park_sel] = m_park_data;
            m_pulse           = 4'b0001 << m_park_sel;
            m_parked          = 1'b0;
         end
      end else if (acc) begin
         if (h) begin
            m_park_data = d;
            m_park_sel  = s;
            m_parked    = 1'b1;
         end else begin
            m_out[s] = d;
            m_pulse  = 4'b0001 << s;
         end
      end
      @(posedge clk);
      #1;
      checkAll(tag);
   endtask

   task automatic doReset();
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'($urandom);
      in_data  = 8'($urandom);
      in_sel   = 2'($urandom);
      hold     = 1'($urandom);
      #1;
      modelReset();
      checkOutput("rst.out0", {24'd0, out0}, 32'h00);
      checkOutput("rst.out1", {24'd0, out1}, 32'h00);
      checkOutput("rst.out2", {24'd0, out2}, 32'h00);
      checkOutput("rst.out3", {24'd0, out3}, 32'h00);
      checkOutput("rst.wr_pulse", {28'd0, wr_pulse}, 32'h0);
      checkOutput("rst.pending", {31'd0, pending}, 32'h0);
      @(posedge clk);
      #1;
      checkOutput("rst.hold_pulse", {28'd0, wr_pulse}, 32'h0);
      @(negedge clk);
      in_valid = 1'b0;
      hold     = 1'b0;
      rst_n    = 1'b1;
      #1;
      checkOutput("rst.in_ready", {31'd0, in_ready}, 32'h1);
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst_n        = 1'b0;
      in_valid     = 1'b0;
      in_data      = 8'h00;
      in_sel       = 2'd0;
      hold         = 1'b0;
      modelReset();

      doReset();

      // Single write to slot 2; the pulse must last exactly one cycle.
      applyStimulus(1'b1, 8'hA5, 2'd2, 1'b0, "t2.write");
      checkOutput("t2.out2_abs", {24'd0, out2}, 32'hA5);
      checkOutput("t2.pulse_abs", {28'd0, wr_pulse}, 32'h4);
      applyStimulus(1'b0, 8'h00, 2'd0, 1'b0, "t2.idle");
      checkOutput("t2.pulse_gone", {28'd0, wr_pulse}, 32'h0);

      // Every select with every data value.
      for (int s = 0; s < 4; s++)
         for (int d = 0; d < 256; d++)
            applyStimulus(1'b1, 8'(d), 2'(s), 1'b0, "t3.exh");

      // Park under hold, refuse a second write, then commit on release.
      applyStimulus(1'b1, 8'h3C, 2'd1, 1'b1, "t4.park");
      applyStimulus(1'b1, 8'h77, 2'd0, 1'b1, "t4.ignored");
      applyStimulus(1'b0, 8'h00, 2'd0, 1'b0, "t4.release");
      checkOutput("t4.out1_abs", {24'd0, out1}, 32'h3C);
      checkOutput("t4.pulse_abs", {28'd0, wr_pulse}, 32'h2);
      applyStimulus(1'b0, 8'h00, 2'd0, 1'b0, "t4.after");

      // Hold toggling with nothing accepted changes nothing.
      applyStimulus(1'b0, 8'hFF, 2'd3, 1'b1, "t4.hold_idle");
      applyStimulus(1'b0, 8'hFF, 2'd3, 1'b0, "t4.unhold_idle");

      // Reset while parked discards the transaction.
      doReset();
      applyStimulus(1'b1, 8'h3C, 2'd1, 1'b1, "t5.park");
      doReset();
      applyStimulus(1'b0, 8'h00, 2'd0, 1'b1, "t5.post_hold");
      applyStimulus(1'b0, 8'h00, 2'd0, 1'b0, "t5.drop_hold");
      applyStimulus(1'b0, 8'h00, 2'd0, 1'b0, "t5.quiet");
      checkOutput("t5.out1_abs", {24'd0, out1}, 32'h00);

      // Back-to-back writes to slot 3 keep its pulse bit high.
      for (int i = 1; i <= 10; i++) begin
         applyStimulus(1'b1, 8'(i), 2'd3, 1'b0, "t6.b2b");
         checkOutput("t6.pulse_abs", {28'd0, wr_pulse}, 32'h8);
      end
      applyStimulus(1'b0, 8'h00, 2'd0, 1'b0, "t6.end");

      // Random traffic with frequent stalls.
      for (int n = 0; n < 3000; n++)
         applyStimulus(1'($urandom_range(0, 3) != 0), 8'($urandom), 2'($urandom),
                       1'($urandom_range(0, 2) == 0), "rnd");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
